prbs_checker: RTL and testbench



---
 rtl/prbs_checker.sv | 155 +++++++++++++++
 tb/tb_prbs_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// +--------------------------------------------------------------------------+
// | Module   : prbs_checker                                                  |
// | Purpose  : Self-synchronising serial PRBS checker for the Fibonacci LFSR |
// |            generator; predicts each bit, flags and counts mismatches.    |
// |            Optional PRBS_CHECKER_BIT_COUNT_EN adds a checked-bit counter. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module prbs_checker #(
   parameter int             WIDTH       = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'b1000000001011,
   parameter bit             INVERT      = 1'b0,
   parameter int             SYNC_CNT    = 8,
   parameter int             LOSS_WIN    = 64,
   parameter int             LOSS_THRESH = 8,
   parameter int             CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             din,
   input  logic             err_clr,
   output logic             locked,
   output logic             err,
`ifdef PRBS_CHECKER_BIT_COUNT_EN
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
`else
   output logic [CNT_W-1:0] err_count
`endif
);

   localparam int c_FILL_W = $clog2(WIDTH + 1);
   localparam int c_SYNC_W = 8;
   localparam int c_BLK_W  = $clog2(LOSS_WIN + 1);
   localparam int c_BERR_W = $clog2(LOSS_THRESH + 1);
   localparam logic [WIDTH-1:0] c_LOCKUP = {WIDTH{INVERT}};

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t              r_state;
   logic [WIDTH-1:0]    r_s;
   logic [c_FILL_W-1:0] r_fill;
   logic [c_SYNC_W-1:0] r_sync;
   logic [c_BLK_W-1:0]  r_blk;
   logic [c_BERR_W-1:0] r_berr;

   logic                w_exp;
   logic                w_mis;
   logic [c_FILL_W-1:0] w_fill_nxt;
   logic [c_SYNC_W-1:0] w_sync_nxt;
   logic [c_BLK_W-1:0]  w_blk_nxt;
   logic [c_BERR_W-1:0] w_berr_nxt;

   assign w_exp      = (^(r_s & TAPS)) ^ INVERT;
   assign w_mis      = din ^ w_exp;
   assign w_fill_nxt = r_fill + c_FILL_W'(1);
   assign w_sync_nxt = r_sync + c_SYNC_W'(1);
   assign w_blk_nxt  = r_blk + c_BLK_W'(1);
   assign w_berr_nxt = r_berr + c_BERR_W'(w_mis);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_HUNT;
         r_s       <= '0;
         r_fill    <= '0;
         r_sync    <= '0;
         r_blk     <= '0;
         r_berr    <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         err <= 1'b0;
         if (enable) begin
            case (r_state)
               ST_HUNT: begin
                  r_s <= {din, r_s[WIDTH-1:1]};
                  if (w_fill_nxt == c_FILL_W'(WIDTH)) begin
                     r_state <= ST_VERIFY;
                     r_sync  <= '0;
                  end else begin
                     r_fill <= w_fill_nxt;
                  end
               end
               ST_VERIFY: begin
                  // A lockup-pattern window would predict itself forever, so it never verifies.
                  if (!w_mis && (r_s != c_LOCKUP)) begin
                     r_s <= {din, r_s[WIDTH-1:1]};
                     if (w_sync_nxt == c_SYNC_W'(SYNC_CNT)) begin
                        r_state <= ST_LOCKED;
                        r_blk   <= '0;
                        r_berr  <= '0;
                        locked  <= 1'b1;
                     end else begin
                        r_sync <= w_sync_nxt;
                     end
                  end else begin
                     r_state <= ST_HUNT;
                     r_fill  <= '0;
                  end
               end
               ST_LOCKED: begin
                  // Flywheel: the window follows the prediction, not the received bit.
                  r_s <= {w_exp, r_s[WIDTH-1:1]};
                  if (w_mis) begin
                     err <= 1'b1;
                     if (!(&err_count))
                        err_count <= err_count + CNT_W'(1);
                  end
                  if (w_mis && (w_berr_nxt == c_BERR_W'(LOSS_THRESH))) begin
                     r_state <= ST_HUNT;
                     r_fill  <= '0;
                     locked  <= 1'b0;
                  end else if (w_blk_nxt == c_BLK_W'(LOSS_WIN)) begin
                     r_blk  <= '0;
                     r_berr <= '0;
                  end else begin
                     r_blk  <= w_blk_nxt;
                     r_berr <= w_berr_nxt;
                  end
               end
               default: begin
                  r_state <= ST_HUNT;
                  r_fill  <= '0;
                  locked  <= 1'b0;
               end
            endcase
         end
         if (err_clr)
            err_count <= '0;
      end
   end

`ifdef PRBS_CHECKER_BIT_COUNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         bit_count <= '0;
      end else begin
         if (enable && (r_state == ST_LOCKED) && !(&bit_count))
            bit_count <= bit_count + CNT_W'(1);
         if (err_clr)
            bit_count <= '0;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_prbs_checker                                               |
// | Purpose  : Self-checking bench for prbs_checker with reference LFSR and  |
// |            scoreboarded checker model.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_prbs_checker;

   localparam int          WIDTH       = 16;
   localparam logic [15:0] TAPS        = 16'b1000000001011;
   localparam bit          INVERT      = 1'b0;
   localparam int          SYNC_CNT    = 8;
   localparam int          LOSS_WIN    = 64;
   localparam int          LOSS_THRESH = 8;
   localparam int          CNT_W       = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             enable = 1'b0;
   logic             din = 1'b0;
   logic             err_clr = 1'b0;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_count;
`ifdef PRBS_CHECKER_BIT_COUNT_EN
   logic [CNT_W-1:0] bit_count;
`endif

   always #5 clk = ~clk;

   prbs_checker #(
      .WIDTH(WIDTH), .TAPS(TAPS), .INVERT(INVERT), .SYNC_CNT(SYNC_CNT),
      .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .din(din),
      .err_clr(err_clr),
      .locked(locked),
      .err(err),
`ifdef PRBS_CHECKER_BIT_COUNT_EN
      .err_count(err_count),
      .bit_count(bit_count)
`else
      .err_count(err_count)
`endif
   );

   typedef struct packed {
      logic             lk;
      logic             er;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] bits;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   err_seen = 0;
   int   lock_seen = 0;

   // Reference checker model state (0=hunt, 1=verify, 2=locked)
   int          m_state = 0;
   logic [15:0] m_s = '0;
   int          m_fill = 0, m_sync = 0, m_blk = 0, m_berr = 0;
   logic             m_locked = 1'b0, m_err = 1'b0;
   logic [CNT_W-1:0] m_cnt = '0, m_bits = '0;

   logic [15:0] g = 16'h0001;

   function automatic logic pred(input logic [15:0] s);
      return (^(s & TAPS)) ^ INVERT;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst_n, input logic en, input logic d, input logic clr);
      logic p;
      if (!rst_n) begin
         m_state = 0; m_s = '0; m_fill = 0; m_sync = 0; m_blk = 0; m_berr = 0;
         m_locked = 1'b0; m_err = 1'b0; m_cnt = '0; m_bits = '0;
      end else begin
         m_err = 1'b0;
         p = pred(m_s);
         if (en) begin
            if (m_state == 0) begin
               m_s = {d, m_s[15:1]};
               m_fill++;
               if (m_fill == WIDTH) begin m_state = 1; m_sync = 0; end
            end else if (m_state == 1) begin
               if (d == p && m_s != {16{INVERT}}) begin
                  m_s = {d, m_s[15:1]};
                  m_sync++;
                  if (m_sync == SYNC_CNT) begin m_state = 2; m_blk = 0; m_berr = 0; end
               end else begin
                  m_state = 0; m_fill = 0;
               end
            end else begin
               m_s = {p, m_s[15:1]};
               if (m_bits != '1) m_bits = m_bits + 1;
               m_blk++;
               if (d != p) begin
                  m_err = 1'b1;
                  if (m_cnt != '1) m_cnt = m_cnt + 1;
                  m_berr++;
               end
               if (d != p && m_berr == LOSS_THRESH) begin
                  m_state = 0; m_fill = 0;
               end else if (m_blk == LOSS_WIN) begin
                  m_blk = 0; m_berr = 0;
               end
            end
         end
         if (clr) begin m_cnt = '0; m_bits = '0; end
         m_locked = (m_state == 2);
      end
   endtask

   task automatic step(input logic rst_n, input logic en, input logic d, input logic clr);
      exp_t e;
      reset = rst_n; enable = en; din = d; err_clr = clr;
      model_edge(rst_n, en, d, clr);
      e.lk = m_locked; e.er = m_err; e.cnt = m_cnt; e.bits = m_bits;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("locked", 64'(locked), 64'(e.lk));
      check("err", 64'(err), 64'(e.er));
      check("err_count", 64'(err_count), 64'(e.cnt));
`ifdef PRBS_CHECKER_BIT_COUNT_EN
      check("bit_count", 64'(bit_count), 64'(e.bits));
`endif
      if (err === 1'b1) err_seen++;
      if (locked === 1'b1) lock_seen++;
      reset = 1'b1; enable = 1'b0; err_clr = 1'b0;
   endtask

   // One generator step, optionally corrupting the transmitted bit.
   task automatic gen_step(input logic inv, input logic clr);
      step(1'b1, 1'b1, g[0] ^ inv, clr);
      g = {pred(g), g[15:1]};
   endtask

   task automatic measure_lock(input string tag);
      int lat;
      lat = 0;
      while (locked !== 1'b1 && lat < 100) begin
         gen_step(1'b0, 1'b0);
         lat++;
      end
      check(tag, 64'(lat), 64'(WIDTH + SYNC_CNT));
   endtask

   initial begin
      int r;
      // Reset
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_locked", 64'(locked), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);

      // Clean lock and 1000 clean bits
      g = 16'h0001;
      err_seen = 0;
      measure_lock("lock_latency");
      for (int i = WIDTH + SYNC_CNT; i < 1000; i++) gen_step(1'b0, 1'b0);
      check("clean_err_pulses", 64'(err_seen), 64'd0);
      check("clean_err_count", 64'(err_count), 64'd0);

      // Single error, then flywheel
      gen_step(1'b1, 1'b0);
      check("single_err", 64'(err), 64'd1);
      check("single_count", 64'(err_count), 64'd1);
      check("single_locked", 64'(locked), 64'd1);
      err_seen = 0;
      for (int i = 0; i < 100; i++) gen_step(1'b0, 1'b0);
      check("flywheel_err_pulses", 64'(err_seen), 64'd0);

      // Burst loss within one block
      gen_step(1'b0, 1'b1);
      check("clr_count", 64'(err_count), 64'd0);
      for (int i = 0; i < LOSS_WIN && m_blk != 0; i++) gen_step(1'b0, 1'b0);
      for (int i = 0; i < LOSS_THRESH - 1; i++) gen_step(1'b1, 1'b0);
      check("burst_still_locked", 64'(locked), 64'd1);
      gen_step(1'b1, 1'b0);
      check("burst_unlocked", 64'(locked), 64'd0);
      check("burst_count", 64'(err_count), 64'd8);
      measure_lock("relock_latency");
      check("relock_count", 64'(err_count), 64'd8);

      // Random enable gaps after lock
      err_seen = 0;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 1));
         if (r == 1) gen_step(1'b0, 1'b0);
         else step(1'b1, 1'b0, 1'(int'($urandom_range(0, 1))), 1'b0);
      end
      check("gap_err_pulses", 64'(err_seen), 64'd0);
      check("gap_locked", 64'(locked), 64'd1);

      // Clear coincident with an error
      gen_step(1'b1, 1'b1);
      check("clr_err_pulse", 64'(err), 64'd1);
      check("clr_wins", 64'(err_count), 64'd0);

      // Five spaced errors, then reset mid-lock
      for (int k = 0; k < 5; k++) begin
         gen_step(1'b1, 1'b0);
         for (int i = 0; i < 10; i++) gen_step(1'b0, 1'b0);
      end
      check("five_count", 64'(err_count), 64'd5);
      check("five_locked", 64'(locked), 64'd1);
      step(1'b0, 1'b1, g[0], 1'b0);
      check("midrst_locked", 64'(locked), 64'd0);
      check("midrst_count", 64'(err_count), 64'd0);
      measure_lock("midrst_relock");

      // Stuck-at-zero line
      step(1'b0, 1'b0, 1'b0, 1'b0);
      err_seen = 0;
      lock_seen = 0;
      for (int i = 0; i < 500; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      check("stuck_lock_seen", 64'(lock_seen), 64'd0);
      check("stuck_err_seen", 64'(err_seen), 64'd0);
      check("stuck_count", 64'(err_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
